hdmi_vram_arbiter: RTL and testbench
====================================

Name: hdmi_vram_arbiter

Overview:
Shares the single-port 32-bit VRAM of the HDMI text controller between two requesters: the AXI4-Lite slave interface (CPU register/VRAM accesses) and the display character fetcher. The display fetcher has absolute priority and is never stalled. AXI accesses take free RAM slots, one outstanding transaction at a time. The block sits between the AXI4-Lite slave ports and the VRAM primitive, replacing direct slave-to-register wiring.

Parameters:
ADDR_W, 10, VRAM word-address width (1024 x 32-bit words)
C_S_AXI_ADDR_WIDTH, 12, AXI byte-address width
RD_LAT, 2, VRAM read latency in cycles (1..4)
STARVE_MAX, 16, AXI wait-cycle threshold for the starvation flag

Ports:
ACLK  in  1  clock; all logic is on the rising edge
ARESETN  in  1  reset, synchronous, active-low
s_axi_awaddr  in  C_S_AXI_ADDR_WIDTH  write address
s_axi_awvalid / s_axi_awready  in/out  1  AW handshake
s_axi_wdata  in  32  write data
s_axi_wstrb  in  4  byte strobes
s_axi_wvalid / s_axi_wready  in/out  1  W handshake
s_axi_bresp  out  2  write response, always 2'b00
s_axi_bvalid / s_axi_bready  out/in  1  B handshake
s_axi_araddr  in  C_S_AXI_ADDR_WIDTH  read address
s_axi_arvalid / s_axi_arready  in/out  1  AR handshake
s_axi_rdata  out  32  read data
s_axi_rresp  out  2  read response, always 2'b00
s_axi_rvalid / s_axi_rready  out/in  1  R handshake
disp_req  in  1  display fetch request this cycle
disp_addr  in  ADDR_W  display word address
disp_rdata  out  32  display read data
disp_rvalid  out  1  disp_rdata valid
ram_en  out  1  VRAM enable
ram_we  out  4  VRAM byte write enables
ram_addr  out  ADDR_W  VRAM word address
ram_wdata  out  32  VRAM write data
ram_rdata  in  32  VRAM read data, valid RD_LAT cycles after ram_en with ram_we=0
axi_starved  out  1  sticky starvation flag

Behaviour:
- Reset (ARESETN=0 at a clock edge): FSM=IDLE; every output 0, including axi_starved, rdata and the tag pipe. Reset in mid-transaction abandons the transaction: no B/R response is issued, and in-flight read returns are discarded.
- FSM states: IDLE, WR_ISSUE, WR_RESP, RD_ISSUE, RD_WAIT, RD_RESP.
- IDLE, write: when awvalid && wvalid, pulse awready and wready together for 1 cycle, latch word address = awaddr[ADDR_W+1:2] (upper bits ignored, so addresses wrap), latch wdata/wstrb, go to WR_ISSUE.
  - AW without W, or W without AW: neither is accepted.
- IDLE, read: when arvalid and no write is acceptable, pulse arready for 1 cycle, latch address, go to RD_ISSUE.
  - AW+W and AR present together: the write wins. AR is accepted only after the B handshake completes.
- WR_ISSUE: in the first cycle with disp_req=0, drive ram_en=1, ram_we=wstrb, ram_addr/ram_wdata from the latches, then go to WR_RESP.
- WR_RESP: bvalid=1 until bready=1, then IDLE.
- RD_ISSUE: in the first cycle with disp_req=0, issue the read (ram_we=0) and go to RD_WAIT.
- RD_WAIT: count RD_LAT cycles, capture ram_rdata into the rdata register, go to RD_RESP.
- RD_RESP: rvalid=1 until rready=1, then IDLE.
- Display path: disp_req=1 drives ram_en=1, ram_we=0, ram_addr=disp_addr that same cycle, regardless of FSM state.
  - disp_rvalid asserts exactly RD_LAT cycles later, with disp_rdata=ram_rdata.
  - A 1-bit-per-stage tag shift register (depth RD_LAT) marks display vs AXI returns.
- RAM-port muxing is combinational from state and disp_req. Display reads in the same cycle as a pending write see the old data. Writes commit at the issue cycle, so later reads see them.
- Latency with disp_req=0 (handshake at T):
  - write: ram_we at T+1, bvalid at T+2
  - read: ram_en at T+1, rvalid at T+2+RD_LAT (T+4 at default)
- Starvation counter:
  - increments each cycle in WR_ISSUE or RD_ISSUE while disp_req=1; clears on issue
  - saturates at STARVE_MAX
  - reaching STARVE_MAX sets axi_starved, which clears only on reset

Decomposition:
- Package hdmi_text_pkg holds: state enum arb_state_t, AXI_RESP_OKAY=2'b00, default ADDR_W/RD_LAT constants.
- One sub-module, hdmi_rd_tag_pipe: parameterised RD_LAT shift register carrying the valid bit and display/AXI tag, with synchronous active-low clear.

Test Plan:
1. Hold ARESETN=0 for 5 cycles with random inputs -> all outputs 0 and axi_starved=0; first cycle after release, awready=wready=arready=0 unless requests are present.
2. disp_req=0, write 0xDEADBEEF to byte addr 0x010 with wstrb=4'hF -> ram_we=4'hF, ram_addr=4 at T+1, bvalid at T+2; read 0x010 -> rvalid at T+4 with rdata=0xDEADBEEF, rresp=0.
3. Preload word 4 with 0xFFFFFFFF, write 0x0000ABCD with wstrb=4'b0011 -> readback 0xFFFFABCD; write to byte addr 0x1010 aliases word 4.
4. disp_req=1 for 20 cycles, addresses 0..19, during a pending write -> disp_rvalid every cycle at latency 2 with correct data; write issues the cycle disp_req drops; axi_starved sets after 16 wait cycles and stays set.
5. AW/W and AR asserted in the same cycle -> awready/wready first; arready only in the cycle after bready completes; read returns the newly written data.
6. ARESETN pulled low in RD_WAIT, then released -> no rvalid ever appears for that read, and the next read completes normally.

Source files
------------

// File: rtl/hdmi_text_pkg.sv
// rtl/hdmi_text_pkg.sv - shared types and constants for the HDMI text VRAM path
package hdmi_text_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WR_ISSUE = 3'd1,
        WR_RESP  = 3'd2,
        RD_ISSUE = 3'd3,
        RD_WAIT  = 3'd4,
        RD_RESP  = 3'd5
    } arb_state_t;

    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    localparam int         DEFAULT_ADDR_W = 10;
    localparam int         DEFAULT_RD_LAT = 2;

endpackage

// File: rtl/hdmi_rd_tag_pipe.sv
// rtl/hdmi_rd_tag_pipe.sv - read-return shift register tagging display vs AXI reads
module hdmi_rd_tag_pipe
    import hdmi_text_pkg::*;
#(
    parameter int RD_LAT = DEFAULT_RD_LAT
) (
    input  logic clk,
    input  logic resetn,
    input  logic in_valid,
    input  logic in_disp,
    output logic out_valid,
    output logic out_disp
);

    logic [RD_LAT-1:0] valid_sr;
    logic [RD_LAT-1:0] disp_sr;

    // Shift one stage per cycle so the tag lines up with the RAM's read data
    always_ff @(posedge clk) begin
        if (!resetn) begin
            valid_sr <= '0;
            disp_sr  <= '0;
        end else begin
            valid_sr[0] <= in_valid;
            disp_sr[0]  <= in_disp;
            for (int i = 1; i < RD_LAT; i++) begin
                valid_sr[i] <= valid_sr[i-1];
                disp_sr[i]  <= disp_sr[i-1];
            end
        end
    end

    assign out_valid = valid_sr[RD_LAT-1];
    assign out_disp  = disp_sr[RD_LAT-1];

endmodule

// File: rtl/hdmi_vram_arbiter.sv
// rtl/hdmi_vram_arbiter.sv - VRAM port arbiter between display fetcher and AXI4-Lite slave
module hdmi_vram_arbiter
    import hdmi_text_pkg::*;
#(
    parameter int ADDR_W             = DEFAULT_ADDR_W,
    parameter int C_S_AXI_ADDR_WIDTH = 12,
    parameter int RD_LAT             = DEFAULT_RD_LAT,
    parameter int STARVE_MAX         = 16
) (
    input  logic                          ACLK,
    input  logic                          ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic                          s_axi_awvalid,
    output logic                          s_axi_awready,
    input  logic [31:0]                   s_axi_wdata,
    input  logic [3:0]                    s_axi_wstrb,
    input  logic                          s_axi_wvalid,
    output logic                          s_axi_wready,
    output logic [1:0]                    s_axi_bresp,
    output logic                          s_axi_bvalid,
    input  logic                          s_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic                          s_axi_arvalid,
    output logic                          s_axi_arready,
    output logic [31:0]                   s_axi_rdata,
    output logic [1:0]                    s_axi_rresp,
    output logic                          s_axi_rvalid,
    input  logic                          s_axi_rready,
    input  logic                          disp_req,
    input  logic [ADDR_W-1:0]             disp_addr,
    output logic [31:0]                   disp_rdata,
    output logic                          disp_rvalid,
    output logic                          ram_en,
    output logic [3:0]                    ram_we,
    output logic [ADDR_W-1:0]             ram_addr,
    output logic [31:0]                   ram_wdata,
    input  logic [31:0]                   ram_rdata,
    output logic                          axi_starved
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    arb_state_t        state;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [3:0]        wstrb_q;
    logic [CNT_W-1:0]  starve_cnt;

    logic disp_grant;
    logic axi_wr_issue;
    logic axi_rd_issue;
    logic pipe_in_valid;
    logic pipe_valid;
    logic pipe_disp;
    logic wr_offer;
    logic offer_slot;
    logic unused_addr_bits;

    // Byte-lane bits never select a word; the upper bits beyond ADDR_W+2 wrap
    assign unused_addr_bits = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};

    assign s_axi_bresp = AXI_RESP_OKAY;
    assign s_axi_rresp = AXI_RESP_OKAY;

    // Display always owns the port when it asks; AXI only issues in a free slot
    assign disp_grant   = ARESETN && disp_req;
    assign axi_wr_issue = ARESETN && !disp_req && (state == WR_ISSUE);
    assign axi_rd_issue = ARESETN && !disp_req && (state == RD_ISSUE);

    // A new AXI request is offered from IDLE, or directly as a response completes
    assign wr_offer   = s_axi_awvalid && s_axi_wvalid;
    assign offer_slot = ((state == IDLE) && !s_axi_awready && !s_axi_arready) ||
                        ((state == WR_RESP) && s_axi_bready) ||
                        ((state == RD_RESP) && s_axi_rready);

    // Combinational RAM port mux: display first, then the pending AXI access
    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 4'h0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (disp_grant) begin
            ram_en   = 1'b1;
            ram_addr = disp_addr;
        end else if (axi_wr_issue) begin
            ram_en    = 1'b1;
            ram_we    = wstrb_q;
            ram_addr  = addr_q;
            ram_wdata = wdata_q;
        end else if (axi_rd_issue) begin
            ram_en   = 1'b1;
            ram_addr = addr_q;
        end
    end

    assign pipe_in_valid = disp_grant || axi_rd_issue;

    hdmi_rd_tag_pipe #(
        .RD_LAT (RD_LAT)
    ) u_tag_pipe (
        .clk       (ACLK),
        .resetn    (ARESETN),
        .in_valid  (pipe_in_valid),
        .in_disp   (disp_grant),
        .out_valid (pipe_valid),
        .out_disp  (pipe_disp)
    );

    assign disp_rvalid = pipe_valid && pipe_disp;
    assign disp_rdata  = disp_rvalid ? ram_rdata : 32'h0;

    // AXI transaction FSM: one outstanding access, registered handshakes
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            state         <= IDLE;
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
            s_axi_arready <= 1'b0;
            s_axi_bvalid  <= 1'b0;
            s_axi_rvalid  <= 1'b0;
            s_axi_rdata   <= '0;
            addr_q        <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (s_axi_awready) begin
                        s_axi_awready <= 1'b0;
                        s_axi_wready  <= 1'b0;
                        if (wr_offer) begin
                            addr_q  <= s_axi_awaddr[ADDR_W+1:2];
                            wdata_q <= s_axi_wdata;
                            wstrb_q <= s_axi_wstrb;
                            state   <= WR_ISSUE;
                        end
                    end else if (s_axi_arready) begin
                        s_axi_arready <= 1'b0;
                        if (s_axi_arvalid) begin
                            addr_q <= s_axi_araddr[ADDR_W+1:2];
                            state  <= RD_ISSUE;
                        end
                    end
                end
                WR_ISSUE: begin
                    if (!disp_req) begin
                        s_axi_bvalid <= 1'b1;
                        state        <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (s_axi_bready) begin
                        s_axi_bvalid <= 1'b0;
                        state        <= IDLE;
                    end
                end
                RD_ISSUE: begin
                    if (!disp_req) begin
                        state <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (pipe_valid && !pipe_disp) begin
                        s_axi_rdata  <= ram_rdata;
                        s_axi_rvalid <= 1'b1;
                        state        <= RD_RESP;
                    end
                end
                RD_RESP: begin
                    if (s_axi_rready) begin
                        s_axi_rvalid <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (offer_slot) begin
                if (wr_offer) begin
                    s_axi_awready <= 1'b1;
                    s_axi_wready  <= 1'b1;
                end else if (s_axi_arvalid) begin
                    s_axi_arready <= 1'b1;
                end
            end
        end
    end

    // Count display-blocked issue cycles; the flag is sticky until reset
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            starve_cnt  <= '0;
            axi_starved <= 1'b0;
        end else if (((state == WR_ISSUE) || (state == RD_ISSUE)) && disp_req) begin
            if (starve_cnt != CNT_W'(STARVE_MAX)) begin
                starve_cnt <= starve_cnt + CNT_W'(1);
            end
            if (starve_cnt == CNT_W'(STARVE_MAX - 1)) begin
                axi_starved <= 1'b1;
            end
        end else if (axi_wr_issue || axi_rd_issue) begin
            starve_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_hdmi_vram_arbiter.sv
// tb/tb_hdmi_vram_arbiter.sv - directed scoreboard bench for hdmi_vram_arbiter
module tb_hdmi_vram_arbiter;

    localparam int RD_LAT = 2;

    typedef struct {
        int          c;
        logic [31:0] d;
    } disp_exp_t;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [11:0] awaddr = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;
    logic [11:0] araddr = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b0;
    logic        disp_req = 1'b0;
    logic [9:0]  disp_addr = '0;
    logic [31:0] disp_rdata;
    logic        disp_rvalid;
    logic        ram_en;
    logic [3:0]  ram_we;
    logic [9:0]  ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic        axi_starved;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [31:0] shadow [0:1023];
    logic [31:0] vram [0:1023];
    bit          written [0:1023];
    logic [31:0] rd_sr [0:RD_LAT-1];
    logic [31:0] cur;

    disp_exp_t   disp_q [$];
    logic [31:0] rd_q [$];
    logic        mon_ev;
    disp_exp_t   mon_e;

    hdmi_vram_arbiter dut (
        .ACLK          (clk),
        .ARESETN       (resetn),
        .s_axi_awaddr  (awaddr),
        .s_axi_awvalid (awvalid),
        .s_axi_awready (awready),
        .s_axi_wdata   (wdata),
        .s_axi_wstrb   (wstrb),
        .s_axi_wvalid  (wvalid),
        .s_axi_wready  (wready),
        .s_axi_bresp   (bresp),
        .s_axi_bvalid  (bvalid),
        .s_axi_bready  (bready),
        .s_axi_araddr  (araddr),
        .s_axi_arvalid (arvalid),
        .s_axi_arready (arready),
        .s_axi_rdata   (rdata),
        .s_axi_rresp   (rresp),
        .s_axi_rvalid  (rvalid),
        .s_axi_rready  (rready),
        .disp_req      (disp_req),
        .disp_addr     (disp_addr),
        .disp_rdata    (disp_rdata),
        .disp_rvalid   (disp_rvalid),
        .ram_en        (ram_en),
        .ram_we        (ram_we),
        .ram_addr      (ram_addr),
        .ram_wdata     (ram_wdata),
        .ram_rdata     (ram_rdata),
        .axi_starved   (axi_starved)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] init_word(input int i);
        return 32'h5A00_0000 ^ (32'(i) * 32'h0001_0203);
    endfunction

    always @(posedge clk) begin
        if (ram_en === 1'b1) begin
            cur = written[ram_addr] ? vram[ram_addr] : init_word(int'(ram_addr));
            if (ram_we != 4'h0) begin
                for (int b = 0; b < 4; b++)
                    if (ram_we[b]) cur[8*b +: 8] = ram_wdata[8*b +: 8];
                vram[ram_addr]    <= cur;
                written[ram_addr] <= 1'b1;
            end else begin
                rd_sr[0] <= cur;
            end
        end
        for (int i = 1; i < RD_LAT; i++) rd_sr[i] <= rd_sr[i-1];
    end
    assign ram_rdata = rd_sr[RD_LAT-1];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        #2;
        mon_ev = (disp_q.size() != 0) && (disp_q[0].c + RD_LAT == cyc);
        chk("disp_rvalid", 32'(disp_rvalid), 32'(mon_ev));
        if (mon_ev) begin
            mon_e = disp_q.pop_front();
            chk("disp_rdata", disp_rdata, mon_e.d);
        end
    end

    task automatic wait_b(input string tag);
        int n;
        n = 0;
        while (!bvalid && n < 20) begin @(negedge clk); #1; n++; end
        chk({tag, "_blat"}, 32'(n), 32'd1);
        chk({tag, "_bresp"}, 32'(bresp), 32'd0);
        bready = 1'b1;
        @(negedge clk); bready = 1'b0; #1;
        chk({tag, "_bdrop"}, 32'(bvalid), 32'd0);
    endtask

    task automatic wait_r(input string tag, output logic [31:0] got);
        int n;
        logic [31:0] e;
        n = 0;
        while (!rvalid && n < 20) begin @(negedge clk); #1; n++; end
        chk({tag, "_rlat"}, 32'(n), 32'(RD_LAT + 1));
        if (rd_q.size() != 0) e = rd_q.pop_front();
        else e = 'x;
        chk({tag, "_rdata"}, rdata, e);
        chk({tag, "_rresp"}, 32'(rresp), 32'd0);
        got = rdata;
        rready = 1'b1;
        @(negedge clk); rready = 1'b0; #1;
        chk({tag, "_rdrop"}, 32'(rvalid), 32'd0);
    endtask

    task automatic axi_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s);
        int n;
        int w;
        w = (int'(a) >> 2) % 1024;
        @(negedge clk);
        awaddr = a[11:0]; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; #1;
        n = 0;
        while (!(awready && wready) && n < 20) begin @(negedge clk); #1; n++; end
        chk("wr_hs", 32'({awready, wready}), 32'h3);
        for (int b = 0; b < 4; b++)
            if (s[b]) shadow[w][8*b +: 8] = d[8*b +: 8];
        @(negedge clk); awvalid = 1'b0; wvalid = 1'b0; #1;
        chk("wr_issue_we", 32'(ram_we), 32'(s));
        chk("wr_issue_addr", 32'(ram_addr), 32'(w));
        chk("wr_issue_data", ram_wdata, d);
        wait_b("wr");
    endtask

    task automatic axi_read(input logic [15:0] a, output logic [31:0] got);
        int n;
        int w;
        w = (int'(a) >> 2) % 1024;
        @(negedge clk);
        araddr = a[11:0]; arvalid = 1'b1; #1;
        n = 0;
        while (!arready && n < 20) begin @(negedge clk); #1; n++; end
        chk("rd_hs", 32'(arready), 32'd1);
        rd_q.push_back(shadow[w]);
        @(negedge clk); arvalid = 1'b0; #1;
        chk("rd_issue_en", 32'({ram_en, ram_we}), 32'h10);
        chk("rd_issue_addr", 32'(ram_addr), 32'(w));
        wait_r("rd", got);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          n;
        logic [31:0] got;
        disp_exp_t   de;

        for (int i = 0; i < 1024; i++) shadow[i] = init_word(i);

        // reset with random inputs
        resetn = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            awaddr = 12'($urandom); awvalid = 1'($urandom); wdata = $urandom;
            wstrb = 4'($urandom); wvalid = 1'($urandom); bready = 1'($urandom);
            araddr = 12'($urandom); arvalid = 1'($urandom); rready = 1'($urandom);
            disp_req = 1'($urandom); disp_addr = 10'($urandom);
            #1;
            chk("rst_ctrl", 32'({bresp, rresp, awready, wready, arready, bvalid, rvalid,
                                 disp_rvalid, ram_en, axi_starved}), 32'd0);
            chk("rst_ram", 32'({ram_we, ram_addr}), 32'd0);
            chk("rst_data", rdata | ram_wdata | disp_rdata, 32'd0);
        end
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
        disp_req = 1'b0; resetn = 1'b1; #1;
        chk("rel_ready0", 32'({awready, wready, arready}), 32'd0);
        @(negedge clk); #1;
        chk("rel_ready1", 32'({awready, wready, arready, axi_starved}), 32'd0);

        // basic write and read
        axi_write(16'h010, 32'hDEADBEEF, 4'hF);
        axi_read(16'h010, got);
        chk("t2_lit", got, 32'hDEADBEEF);

        // byte strobes and address aliasing
        axi_write(16'h010, 32'hFFFFFFFF, 4'hF);
        axi_write(16'h010, 32'h0000ABCD, 4'b0011);
        axi_read(16'h010, got);
        chk("t3_merge_lit", got, 32'hFFFFABCD);
        axi_write(16'h1010, 32'h12345678, 4'hF);
        axi_read(16'h010, got);
        chk("t3_alias_lit", got, 32'h12345678);

        // display burst holds off a pending write; starvation flag
        @(negedge clk);
        awaddr = 12'h190; wdata = 32'hCAFEF00D; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; #1;
        n = 0;
        while (!awready && n < 20) begin @(negedge clk); #1; n++; end
        chk("t4_aw_hs", 32'(awready), 32'd1);
        shadow[100] = 32'hCAFEF00D;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            awvalid = 1'b0; wvalid = 1'b0; disp_req = 1'b1; disp_addr = 10'(i);
            de.c = cyc; de.d = shadow[i];
            disp_q.push_back(de);
            #1;
            chk("t4_hold_we", 32'(ram_we), 32'd0);
            chk("t4_disp_addr", 32'({ram_en, ram_addr}), 32'h400 | 32'(i));
            if (i == 15) chk("t4_starve_pre", 32'(axi_starved), 32'd0);
            if (i == 16) chk("t4_starve_set", 32'(axi_starved), 32'd1);
        end
        @(negedge clk); disp_req = 1'b0; #1;
        chk("t4_issue_we", 32'(ram_we), 32'hF);
        chk("t4_issue_addr", 32'(ram_addr), 32'd100);
        chk("t4_issue_data", ram_wdata, 32'hCAFEF00D);
        wait_b("t4");
        chk("t4_starve_hold", 32'(axi_starved), 32'd1);
        axi_read(16'h190, got);
        chk("t4_rd_lit", got, 32'hCAFEF00D);
        chk("t4_starve_sticky", 32'(axi_starved), 32'd1);

        // simultaneous write and read: write first, read after B
        @(negedge clk);
        awaddr = 12'h020; wdata = 32'h0BADF00D; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        araddr = 12'h020; arvalid = 1'b1; #1;
        chk("t5_c0", 32'({awready, arready}), 32'd0);
        @(negedge clk); #1;
        chk("t5_aw_first", 32'({awready, wready, arready}), 32'b110);
        shadow[8] = 32'h0BADF00D;
        @(negedge clk); awvalid = 1'b0; wvalid = 1'b0; #1;
        chk("t5_wr_issue", 32'({ram_we, arready}), 32'b11110);
        @(negedge clk); #1;
        chk("t5_bvalid", 32'({bvalid, arready}), 32'b10);
        bready = 1'b1;
        @(negedge clk); bready = 1'b0; #1;
        chk("t5_ar_after_b", 32'({bvalid, arready}), 32'b01);
        rd_q.push_back(shadow[8]);
        @(negedge clk); arvalid = 1'b0; #1;
        chk("t5_rd_issue", 32'({ram_en, ram_we, ram_addr}), 32'h4008);
        wait_r("t5", got);
        chk("t5_lit", got, 32'h0BADF00D);

        // reset during RD_WAIT abandons the read
        @(negedge clk);
        araddr = 12'h010; arvalid = 1'b1; #1;
        n = 0;
        while (!arready && n < 20) begin @(negedge clk); #1; n++; end
        chk("t6_ar_hs", 32'(arready), 32'd1);
        @(negedge clk); arvalid = 1'b0;
        @(negedge clk); resetn = 1'b0;
        @(negedge clk);
        @(negedge clk); resetn = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk); #1;
            chk("t6_no_rvalid", 32'(rvalid), 32'd0);
        end
        chk("t6_starve_clr", 32'(axi_starved), 32'd0);
        axi_read(16'h020, got);
        chk("t6_lit", got, 32'h0BADF00D);

        repeat (4) @(negedge clk);
        #1;
        chk("disp_drain", 32'(disp_q.size()), 32'd0);
        chk("rd_drain", 32'(rd_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
